dual_rail_lut_sweep: RTL and testbench

//  Parametrised, registered N-input Boolean function evaluator with dual-rail (true/complement) inputs.

---
 rtl/dual_rail_lut_sweep_if.sv | 32 +++
 rtl/dual_rail_lut_sweep.sv | 112 +++++++++++
 tb/tb_dual_rail_lut_sweep.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dual_rail_lut_sweep_if.sv
// Interface for the dual-rail LUT evaluator: config, live dual-rail inputs, sweep control and results.
// The master drives stimulus and configuration; the slave is the evaluator.
interface dual_rail_lut_sweep_if #(
  parameter int N_IN = 4
);
  localparam int TW = 1 << N_IN;

  logic            cfg_we;
  logic [TW-1:0]   cfg_table;
  logic            mode;
  logic            start;
  logic [N_IN-1:0] in_p;
  logic [N_IN-1:0] in_n;
  logic            out;
  logic            out_valid;
  logic            rail_err;
  logic            sweep_busy;
  logic            sweep_done;
  logic [N_IN-1:0] sweep_idx;
  logic [TW-1:0]   capture;
  logic [N_IN:0]   ones_count;

  modport master (
    output cfg_we, cfg_table, mode, start, in_p, in_n,
    input  out, out_valid, rail_err, sweep_busy, sweep_done, sweep_idx, capture, ones_count
  );

  modport slave (
    input  cfg_we, cfg_table, mode, start, in_p, in_n,
    output out, out_valid, rail_err, sweep_busy, sweep_done, sweep_idx, capture, ones_count
  );
endinterface

// File: rtl/dual_rail_lut_sweep.sv
// Registered N-input truth-table evaluator with dual-rail inputs: live evaluation with rail
// checking, plus an FSM sweep that walks every minterm and captures the table and its popcount.
module dual_rail_lut_sweep #(
  parameter int N_IN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dual_rail_lut_sweep_if.slave  bus
);
  localparam int TW = 1 << N_IN;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [TW-1:0]   tbl;
  logic            out_p1;
  logic            vld_p1;
  logic            rail_err_p1;
  logic            busy;
  logic            done;
  logic [N_IN-1:0] idx;
  logic [TW-1:0]   cap;
  logic [N_IN:0]   ones;

  logic            rails_ok_p0;
  logic            live_bit_p0;
  logic            sweep_bit;

  // Stage p0: combinational lookup of the presented inputs and the current sweep minterm.
  assign rails_ok_p0 = (bus.in_p == ~bus.in_n);
  assign live_bit_p0 = tbl[bus.in_p];
  assign sweep_bit   = tbl[idx];

  // Stage p1: registered results and FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tbl         <= '0;
      out_p1      <= 1'b0;
      vld_p1      <= 1'b0;
      rail_err_p1 <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      idx         <= '0;
      cap         <= '0;
      ones        <= '0;
    end else begin
      // The table is frozen while a sweep is walking it; lookups above use the old value.
      if (bus.cfg_we && state != RUN)
        tbl <= bus.cfg_table;

      vld_p1      <= 1'b0;
      rail_err_p1 <= 1'b0;
      done        <= 1'b0;

      case (state)
        IDLE: begin
          if (!bus.mode) begin
            if (rails_ok_p0) begin
              out_p1 <= live_bit_p0;
              vld_p1 <= 1'b1;
            end else begin
              rail_err_p1 <= 1'b1;
            end
          end else if (bus.start) begin
            state <= RUN;
            busy  <= 1'b1;
            idx   <= '0;
            cap   <= '0;
            ones  <= '0;
          end
        end

        RUN: begin
          if (!bus.mode) begin
            // Abort keeps whatever was captured so far.
            state <= IDLE;
            busy  <= 1'b0;
            idx   <= '0;
          end else begin
            cap[idx] <= sweep_bit;
            ones     <= ones + {{N_IN{1'b0}}, sweep_bit};
            idx      <= idx + 1'b1;
            if (idx == N_IN'(TW - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out        = out_p1;
  assign bus.out_valid  = vld_p1;
  assign bus.rail_err   = rail_err_p1;
  assign bus.sweep_busy = busy;
  assign bus.sweep_done = done;
  assign bus.sweep_idx  = idx;
  assign bus.capture    = cap;
  assign bus.ones_count = ones;
endmodule

// File: tb/tb_dual_rail_lut_sweep.sv
// Directed bench for dual_rail_lut_sweep: a 4-input instance and a 2-input instance
// sharing clock and reset, exercised scenario by scenario with hand-computed expectations.
module tb_dual_rail_lut_sweep;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dual_rail_lut_sweep_if #(.N_IN(4)) bus4 ();
  dual_rail_lut_sweep_if #(.N_IN(2)) bus2 ();

  dual_rail_lut_sweep #(.N_IN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  dual_rail_lut_sweep #(.N_IN(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus4.cfg_we = 1'b0; bus4.cfg_table = '0; bus4.mode = 1'b0; bus4.start = 1'b0;
    bus4.in_p = 4'b0000; bus4.in_n = 4'b1111;
    bus2.cfg_we = 1'b0; bus2.cfg_table = '0; bus2.mode = 1'b0; bus2.start = 1'b0;
    bus2.in_p = 2'b00; bus2.in_n = 2'b11;
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (bus4.out !== 1'b0) begin n_fail++; $display("FAIL reset_out: got %b expected 0", bus4.out); end
    n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus4.out_valid); end
    n_checks++; if (bus4.rail_err !== 1'b0) begin n_fail++; $display("FAIL reset_rail_err: got %b expected 0", bus4.rail_err); end
    n_checks++; if (bus4.sweep_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus4.sweep_busy); end
    n_checks++; if (bus4.sweep_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus4.sweep_done); end
    n_checks++; if (bus4.sweep_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus4.sweep_idx); end
    n_checks++; if (bus4.capture !== 16'h0000) begin n_fail++; $display("FAIL reset_capture: got %h expected 0000", bus4.capture); end
    n_checks++; if (bus4.ones_count !== 5'd0) begin n_fail++; $display("FAIL reset_ones: got %0d expected 0", bus4.ones_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_live();
    bus4.cfg_we = 1'b1; bus4.cfg_table = 16'h6996;
    tick();
    bus4.cfg_we = 1'b0;
    bus4.in_p = 4'b0011; bus4.in_n = 4'b1100;
    tick();
    n_checks++; if (bus4.out !== 1'b0) begin n_fail++; $display("FAIL live_0011_out: got %b expected 0", bus4.out); end
    n_checks++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL live_0011_valid: got %b expected 1", bus4.out_valid); end
    n_checks++; if (bus4.rail_err !== 1'b0) begin n_fail++; $display("FAIL live_0011_rail_err: got %b expected 0", bus4.rail_err); end
    bus4.in_p = 4'b0111; bus4.in_n = 4'b1000;
    tick();
    n_checks++; if (bus4.out !== 1'b1) begin n_fail++; $display("FAIL live_0111_out: got %b expected 1", bus4.out); end
    // Load and evaluate in the same cycle: evaluation must see the old table.
    bus4.cfg_we = 1'b1; bus4.cfg_table = 16'h0000;
    tick();
    bus4.cfg_we = 1'b0;
    n_checks++; if (bus4.out !== 1'b1) begin n_fail++; $display("FAIL load_same_cycle_old: got %b expected 1", bus4.out); end
    tick();
    n_checks++; if (bus4.out !== 1'b0) begin n_fail++; $display("FAIL load_next_cycle_new: got %b expected 0", bus4.out); end
    bus4.cfg_we = 1'b1; bus4.cfg_table = 16'h6996;
    tick();
    bus4.cfg_we = 1'b0;
    tick();
    n_checks++; if (bus4.out !== 1'b1) begin n_fail++; $display("FAIL reload_out: got %b expected 1", bus4.out); end
  endtask

  task automatic test_rail_err();
    bus4.in_p = 4'b0101; bus4.in_n = 4'b0101;
    tick();
    n_checks++; if (bus4.rail_err !== 1'b1) begin n_fail++; $display("FAIL rail_err_set: got %b expected 1", bus4.rail_err); end
    n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rail_err_valid: got %b expected 0", bus4.out_valid); end
    n_checks++; if (bus4.out !== 1'b1) begin n_fail++; $display("FAIL rail_err_out_hold: got %b expected 1", bus4.out); end
    bus4.in_p = 4'b0000; bus4.in_n = 4'b1111;
    tick();
    n_checks++; if (bus4.rail_err !== 1'b0) begin n_fail++; $display("FAIL rail_err_clear: got %b expected 0", bus4.rail_err); end
    n_checks++; if (bus4.out !== 1'b0 || bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL rail_ok_out: got out=%b valid=%b expected out=0 valid=1", bus4.out, bus4.out_valid); end
  endtask

  task automatic test_sweep();
    int cnt;
    bit saw_done;
    bus4.cfg_we = 1'b1; bus4.cfg_table = 16'hA5C3;
    tick();
    bus4.cfg_we = 1'b0;
    bus4.mode = 1'b1; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    n_checks++; if (bus4.sweep_busy !== 1'b1 || bus4.sweep_idx !== 4'd0) begin n_fail++; $display("FAIL sweep_start: got busy=%b idx=%0d expected busy=1 idx=0", bus4.sweep_busy, bus4.sweep_idx); end
    cnt = 0; saw_done = 1'b0;
    while (bus4.sweep_busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (bus4.sweep_done === 1'b1) saw_done = 1'b1;
      tick();
    end
    n_checks++; if (cnt !== 16) begin n_fail++; $display("FAIL sweep_busy_cycles: got %0d expected 16", cnt); end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL sweep_done_during_busy: got %b expected 0", saw_done); end
    n_checks++; if (bus4.sweep_done !== 1'b1) begin n_fail++; $display("FAIL sweep_done_pulse: got %b expected 1", bus4.sweep_done); end
    n_checks++; if (bus4.capture !== 16'hA5C3) begin n_fail++; $display("FAIL sweep_capture: got %h expected a5c3", bus4.capture); end
    n_checks++; if (bus4.ones_count !== 5'd8) begin n_fail++; $display("FAIL sweep_ones: got %0d expected 8", bus4.ones_count); end
    n_checks++; if (bus4.sweep_idx !== 4'd0) begin n_fail++; $display("FAIL sweep_idx_wrap: got %0d expected 0", bus4.sweep_idx); end
    tick();
    n_checks++; if (bus4.sweep_done !== 1'b0) begin n_fail++; $display("FAIL sweep_done_one_cycle: got %b expected 0", bus4.sweep_done); end
  endtask

  task automatic test_freeze_abort();
    int cnt;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    bus4.cfg_we = 1'b1; bus4.cfg_table = 16'hFFFF;
    cnt = 0;
    while (bus4.sweep_busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    bus4.cfg_we = 1'b0;
    n_checks++; if (cnt !== 16) begin n_fail++; $display("FAIL freeze_busy_cycles: got %0d expected 16", cnt); end
    n_checks++; if (bus4.capture !== 16'hA5C3) begin n_fail++; $display("FAIL freeze_capture: got %h expected a5c3", bus4.capture); end
    n_checks++; if (bus4.ones_count !== 5'd8) begin n_fail++; $display("FAIL freeze_ones: got %0d expected 8", bus4.ones_count); end
    tick();
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    cnt = 0;
    while (bus4.sweep_idx !== 4'd5 && cnt < 40) begin
      cnt++;
      tick();
    end
    n_checks++; if (cnt !== 5) begin n_fail++; $display("FAIL abort_reach_idx5: got %0d cycles expected 5", cnt); end
    bus4.mode = 1'b0;
    tick();
    // Table is still A5C3: bits [4:0] = 00011.
    n_checks++; if (bus4.sweep_busy !== 1'b0 || bus4.sweep_done !== 1'b0) begin n_fail++; $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", bus4.sweep_busy, bus4.sweep_done); end
    n_checks++; if (bus4.sweep_idx !== 4'd0) begin n_fail++; $display("FAIL abort_idx: got %0d expected 0", bus4.sweep_idx); end
    n_checks++; if (bus4.capture !== 16'h0003) begin n_fail++; $display("FAIL abort_capture: got %h expected 0003", bus4.capture); end
    n_checks++; if (bus4.ones_count !== 5'd2) begin n_fail++; $display("FAIL abort_ones: got %0d expected 2", bus4.ones_count); end
    tick();
    n_checks++; if (bus4.sweep_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", bus4.sweep_done); end
  endtask

  task automatic test_async_reset();
    bus4.in_p = 4'b0000; bus4.in_n = 4'b1111;
    tick();
    n_checks++; if (bus4.out !== 1'b1) begin n_fail++; $display("FAIL pre_reset_out: got %b expected 1", bus4.out); end
    bus4.mode = 1'b1; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (bus4.sweep_busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", bus4.sweep_busy); end
    n_checks++; if (bus4.sweep_idx !== 4'd0) begin n_fail++; $display("FAIL async_reset_idx: got %0d expected 0", bus4.sweep_idx); end
    n_checks++; if (bus4.capture !== 16'h0000 || bus4.ones_count !== 5'd0) begin n_fail++; $display("FAIL async_reset_capture: got %h/%0d expected 0000/0", bus4.capture, bus4.ones_count); end
    n_checks++; if (bus4.out !== 1'b0 || bus4.sweep_done !== 1'b0) begin n_fail++; $display("FAIL async_reset_out: got out=%b done=%b expected 0 0", bus4.out, bus4.sweep_done); end
    #2 rst_n = 1'b1;
    bus4.mode = 1'b0;
    tick();
    n_checks++; if (bus4.out !== 1'b0 || bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_table: got out=%b valid=%b expected 0 1", bus4.out, bus4.out_valid); end
  endtask

  task automatic test_n2();
    int cnt;
    bus2.cfg_we = 1'b1; bus2.cfg_table = 4'b1000;
    tick();
    bus2.cfg_we = 1'b0;
    bus2.mode = 1'b1; bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    cnt = 0;
    while (bus2.sweep_busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    n_checks++; if (cnt !== 4) begin n_fail++; $display("FAIL n2_busy_cycles: got %0d expected 4", cnt); end
    n_checks++; if (bus2.sweep_done !== 1'b1) begin n_fail++; $display("FAIL n2_done: got %b expected 1", bus2.sweep_done); end
    n_checks++; if (bus2.capture !== 4'b1000) begin n_fail++; $display("FAIL n2_capture: got %b expected 1000", bus2.capture); end
    n_checks++; if (bus2.ones_count !== 3'd1) begin n_fail++; $display("FAIL n2_ones: got %0d expected 1", bus2.ones_count); end
    tick();
    bus2.mode = 1'b0; bus2.in_p = 2'b11; bus2.in_n = 2'b00;
    tick();
    n_checks++; if (bus2.out !== 1'b1 || bus2.out_valid !== 1'b1) begin n_fail++; $display("FAIL n2_live_11: got out=%b valid=%b expected 1 1", bus2.out, bus2.out_valid); end
    bus2.in_p = 2'b10; bus2.in_n = 2'b01;
    tick();
    n_checks++; if (bus2.out !== 1'b0) begin n_fail++; $display("FAIL n2_live_10: got %b expected 0", bus2.out); end
  endtask

  initial begin
    test_reset();
    test_live();
    test_rail_err();
    test_sweep();
    test_freeze_abort();
    test_async_reset();
    test_n2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
